// File: rtl/pixel_pkg.sv
// Shared types and constants for the pixel write arbiter and its FIFO.
package pixel_pkg;

  localparam int COORD_W = 8;
  localparam int COLOR_W = 3;

  localparam logic SRC_DRAW    = 1'b0;
  localparam logic SRC_RESTORE = 1'b1;

  typedef struct packed {
    logic               src;
    logic [COORD_W-1:0] x;
    logic [COORD_W-1:0] y;
    logic [COLOR_W-1:0] color;
  } pix_wr_t;

endpackage

// File: rtl/pix_fifo_2w1r.sv
// Generic FIFO with two ordered write ports (wr0 lands before wr1) and one read port.
// The caller must never enable more writes than free_cnt allows.
module pix_fifo_2w1r
  import pixel_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int W     = $bits(pix_wr_t)
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     wr0_en,
  input  logic [W-1:0]             wr0_data,
  input  logic                     wr1_en,
  input  logic [W-1:0]             wr1_data,
  input  logic                     rd_en,
  output logic [W-1:0]             rd_data,
  output logic                     empty,
  output logic                     full,
  output logic [$clog2(DEPTH):0]   free_cnt
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH) + 1;

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] rptr;
  logic [AW-1:0] wptr;
  logic [AW-1:0] waddr1;
  logic [CW-1:0] cnt;
  logic          pop;

  assign pop    = rd_en & (cnt != '0);
  assign waddr1 = wptr + AW'(wr0_en);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rptr <= '0;
      wptr <= '0;
      cnt  <= '0;
    end else begin
      rptr <= rptr + AW'(pop);
      wptr <= wptr + AW'(wr0_en) + AW'(wr1_en);
      cnt  <= cnt + CW'(wr0_en) + CW'(wr1_en) - CW'(pop);
    end
  end

  // Storage is not reset; the empty gate on rd_data hides stale contents.
  always_ff @(posedge clk) begin
    if (wr0_en) mem[wptr]   <= wr0_data;
    if (wr1_en) mem[waddr1] <= wr1_data;
  end

  assign empty    = (cnt == '0);
  assign full     = (cnt == CW'(DEPTH));
  assign free_cnt = CW'(DEPTH) - cnt + CW'(pop);
  assign rd_data  = empty ? '0 : mem[rptr];

endmodule

// File: rtl/pixel_write_arb.sv
// Merges live draw writes and undo/redo restore pulses into one ordered framebuffer write stream.
// Optional canvas bounds filtering is enabled by defining PIXEL_WRITE_ARB_BOUNDS_CHECK_EN.
module pixel_write_arb
  import pixel_pkg::*;
#(
  parameter int DEPTH    = 4,
  parameter int CANVAS_W = 160,
  parameter int CANVAS_H = 120
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               draw_req,
  input  logic [COORD_W-1:0] draw_x,
  input  logic [COORD_W-1:0] draw_y,
  input  logic [COLOR_W-1:0] draw_color,
  input  logic               restore_valid,
  input  logic [COORD_W-1:0] restore_x,
  input  logic [COORD_W-1:0] restore_y,
  input  logic [COLOR_W-1:0] restore_color,
  output logic               wr_valid,
  input  logic               wr_ready,
  output logic [COORD_W-1:0] wr_x,
  output logic [COORD_W-1:0] wr_y,
  output logic [COLOR_W-1:0] wr_color,
  output logic               wr_src,
  output logic               busy,
  output logic               overflow,
  input  logic               clear_ovf,
  output logic [7:0]         reject_cnt
);

  localparam int CW = $clog2(DEPTH) + 1;

  pix_wr_t       draw_ent;
  pix_wr_t       rest_ent;
  pix_wr_t       head;
  logic          draw_ok;
  logic          rest_ok;
  logic          fifo_empty;
  logic          fifo_full;
  logic [CW-1:0] free_cnt;
  logic          pop;
  logic          accept_r;
  logic          accept_d;
  logic          drop;

  assign draw_ent = '{src: SRC_DRAW,    x: draw_x,    y: draw_y,    color: draw_color};
  assign rest_ent = '{src: SRC_RESTORE, x: restore_x, y: restore_y, color: restore_color};

`ifdef PIXEL_WRITE_ARB_BOUNDS_CHECK_EN
  logic       draw_oob;
  logic       rest_oob;
  logic [8:0] rej_sum;
  logic [7:0] rej_q;

  assign draw_oob = draw_req &
                    ((32'(draw_x) >= CANVAS_W) | (32'(draw_y) >= CANVAS_H));
  assign rest_oob = restore_valid &
                    ((32'(restore_x) >= CANVAS_W) | (32'(restore_y) >= CANVAS_H));
  assign draw_ok  = draw_req & ~draw_oob;
  assign rest_ok  = restore_valid & ~rest_oob;
  assign rej_sum  = {1'b0, rej_q} + 9'(draw_oob) + 9'(rest_oob);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rej_q <= '0;
    else        rej_q <= rej_sum[8] ? 8'hff : rej_sum[7:0];
  end

  assign reject_cnt = rej_q;
`else
  assign draw_ok    = draw_req;
  assign rest_ok    = restore_valid;
  assign reject_cnt = '0;
`endif

  assign pop = wr_valid & wr_ready;

  // Restore has priority for the first free slot; draw needs a second one if both arrive.
  assign accept_r = rest_ok & (~fifo_full | pop);
  assign accept_d = draw_ok & (free_cnt >= (accept_r ? CW'(2) : CW'(1)));
  assign drop     = (rest_ok & ~accept_r) | (draw_ok & ~accept_d);

  pix_fifo_2w1r #(
    .DEPTH (DEPTH),
    .W     ($bits(pix_wr_t))
  ) u_fifo (
    .clk      (clk),
    .rst_n    (rst_n),
    .wr0_en   (accept_r),
    .wr0_data (rest_ent),
    .wr1_en   (accept_d),
    .wr1_data (draw_ent),
    .rd_en    (wr_ready),
    .rd_data  (head),
    .empty    (fifo_empty),
    .full     (fifo_full),
    .free_cnt (free_cnt)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)         overflow <= 1'b0;
    else if (drop)      overflow <= 1'b1;
    else if (clear_ovf) overflow <= 1'b0;
  end

  assign busy     = ~fifo_empty;
  assign wr_valid = busy;
  assign wr_x     = head.x;
  assign wr_y     = head.y;
  assign wr_color = head.color;
  assign wr_src   = head.src;

endmodule

// File: tb/tb_pixel_write_arb.sv
// Scoreboard bench for pixel_write_arb; bounds tests run when PIXEL_WRITE_ARB_BOUNDS_CHECK_EN is defined.
module tb_pixel_write_arb;

  localparam int DEPTH = 4;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       draw_req = 1'b0;
  logic [7:0] draw_x = '0;
  logic [7:0] draw_y = '0;
  logic [2:0] draw_color = '0;
  logic       restore_valid = 1'b0;
  logic [7:0] restore_x = '0;
  logic [7:0] restore_y = '0;
  logic [2:0] restore_color = '0;
  logic       wr_ready = 1'b0;
  logic       clear_ovf = 1'b0;
  logic       wr_valid;
  logic [7:0] wr_x;
  logic [7:0] wr_y;
  logic [2:0] wr_color;
  logic       wr_src;
  logic       busy;
  logic       overflow;
  logic [7:0] reject_cnt;

  always #5 clk = ~clk;

  pixel_write_arb #(.DEPTH(DEPTH), .CANVAS_W(160), .CANVAS_H(120)) dut (
    .clk(clk), .rst_n(rst_n),
    .draw_req(draw_req), .draw_x(draw_x), .draw_y(draw_y), .draw_color(draw_color),
    .restore_valid(restore_valid), .restore_x(restore_x), .restore_y(restore_y),
    .restore_color(restore_color),
    .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_x(wr_x), .wr_y(wr_y),
    .wr_color(wr_color), .wr_src(wr_src), .busy(busy), .overflow(overflow),
    .clear_ovf(clear_ovf), .reject_cnt(reject_cnt)
  );

  int checks = 0;
  int failures = 0;
  int n_pops = 0;
  logic [19:0] exp_q[$];
  logic [19:0] mon_got;
  logic [19:0] mon_exp;

  // Every accepted write is compared against the oldest expected entry.
  always @(negedge clk) begin
    if (rst_n && wr_valid && wr_ready) begin
      mon_got = {wr_src, wr_x, wr_y, wr_color};
      checks++;
      n_pops++;
      if (exp_q.size() == 0) begin
        failures++;
        $display("FAIL pop_order: got write %h, required none pending", mon_got);
      end else begin
        mon_exp = exp_q.pop_front();
        if (mon_got !== mon_exp) begin
          failures++;
          $display("FAIL pop_order: got %h, required %h", mon_got, mon_exp);
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_draw(input logic en, input int x, input int y, input int c);
    draw_req = en; draw_x = 8'(x); draw_y = 8'(y); draw_color = 3'(c);
  endtask

  task automatic set_rest(input logic en, input int x, input int y, input int c);
    restore_valid = en; restore_x = 8'(x); restore_y = 8'(y); restore_color = 3'(c);
  endtask

  task automatic drain(input string name);
    int n;
    wr_ready = 1'b1;
    n = 0;
    while (wr_valid && n < 40) begin
      step();
      n++;
    end
    checks++;
    if (wr_valid !== 1'b0 || exp_q.size() != 0) begin
      failures++;
      $display("FAIL %s_drain: wr_valid=%b left=%0d, required 0/0", name, wr_valid, exp_q.size());
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if ({wr_valid, busy, overflow, wr_src, wr_x, wr_y, wr_color, reject_cnt} !== '0) begin
      failures++;
      $display("FAIL reset_outputs: v=%b b=%b o=%b s=%b x=%0d y=%0d c=%0d r=%0d, required all 0",
               wr_valid, busy, overflow, wr_src, wr_x, wr_y, wr_color, reject_cnt);
    end
    rst_n = 1'b1;
    step();
  endtask

  task automatic test_single_restore();
    int p0;
    wr_ready = 1'b1;
    set_rest(1'b1, 10, 20, 5);
    exp_q.push_back({1'b1, 8'd10, 8'd20, 3'd5});
    p0 = n_pops;
    checks++;
    if (wr_valid !== 1'b0) begin
      failures++;
      $display("FAIL no_bypass: wr_valid=%b, required 0", wr_valid);
    end
    step();
    set_rest(1'b0, 0, 0, 0);
    checks++;
    if ({wr_valid, wr_src, wr_x, wr_y, wr_color} !== {1'b1, 1'b1, 8'd10, 8'd20, 3'd5}) begin
      failures++;
      $display("FAIL single_restore_head: v=%b s=%b x=%0d y=%0d c=%0d, required 1 1 10 20 5",
               wr_valid, wr_src, wr_x, wr_y, wr_color);
    end
    step();
    checks++;
    if (wr_valid !== 1'b0 || busy !== 1'b0 || n_pops - p0 != 1) begin
      failures++;
      $display("FAIL single_restore_once: v=%b busy=%b pops=%0d, required 0 0 1",
               wr_valid, busy, n_pops - p0);
    end
  endtask

  task automatic test_simultaneous();
    wr_ready = 1'b0;
    set_draw(1'b1, 1, 1, 1);
    set_rest(1'b1, 2, 2, 2);
    exp_q.push_back({1'b1, 8'd2, 8'd2, 3'd2});
    exp_q.push_back({1'b0, 8'd1, 8'd1, 3'd1});
    step();
    set_draw(1'b0, 0, 0, 0);
    set_rest(1'b0, 0, 0, 0);
    step();
    step();
    checks++;
    if ({wr_valid, wr_src, wr_x, wr_color} !== {1'b1, 1'b1, 8'd2, 3'd2}) begin
      failures++;
      $display("FAIL simul_head_hold: v=%b s=%b x=%0d c=%0d, required 1 1 2 2",
               wr_valid, wr_src, wr_x, wr_color);
    end
    wr_ready = 1'b1;
    step();
    checks++;
    if ({wr_valid, wr_src, wr_x} !== {1'b1, 1'b0, 8'd1}) begin
      failures++;
      $display("FAIL simul_second: v=%b s=%b x=%0d, required 1 0 1", wr_valid, wr_src, wr_x);
    end
    step();
    checks++;
    if (wr_valid !== 1'b0) begin
      failures++;
      $display("FAIL simul_empty: wr_valid=%b, required 0", wr_valid);
    end
  endtask

  task automatic fill_draws(input int base);
    wr_ready = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      set_draw(1'b1, base + i, i, i);
      exp_q.push_back({1'b0, 8'(base + i), 8'(i), 3'(i)});
      step();
    end
    set_draw(1'b0, 0, 0, 0);
  endtask

  task automatic test_overflow();
    int p0;
    p0 = n_pops;
    fill_draws(30);
    checks++;
    if (overflow !== 1'b0) begin
      failures++;
      $display("FAIL ovf_before: overflow=%b, required 0", overflow);
    end
    set_draw(1'b1, 99, 99, 7);
    step();
    set_draw(1'b0, 0, 0, 0);
    checks++;
    if (overflow !== 1'b1) begin
      failures++;
      $display("FAIL ovf_set: overflow=%b, required 1", overflow);
    end
    drain("ovf");
    checks++;
    if (n_pops - p0 != DEPTH) begin
      failures++;
      $display("FAIL ovf_count: pops=%0d, required %0d", n_pops - p0, DEPTH);
    end
    clear_ovf = 1'b1;
    step();
    clear_ovf = 1'b0;
    checks++;
    if (overflow !== 1'b0) begin
      failures++;
      $display("FAIL ovf_clear: overflow=%b, required 0", overflow);
    end
  endtask

  task automatic test_full_pop();
    fill_draws(50);
    wr_ready = 1'b1;
    set_draw(1'b1, 60, 0, 0);
    set_rest(1'b1, 61, 1, 6);
    exp_q.push_back({1'b1, 8'd61, 8'd1, 3'd6});
    step();
    set_draw(1'b0, 0, 0, 0);
    set_rest(1'b0, 0, 0, 0);
    checks++;
    if (overflow !== 1'b1 || wr_x !== 8'd51) begin
      failures++;
      $display("FAIL full_pop: overflow=%b head_x=%0d, required 1 51", overflow, wr_x);
    end
    drain("full_pop");
    fill_draws(70);
    set_draw(1'b1, 80, 0, 0);
    clear_ovf = 1'b1;
    step();
    set_draw(1'b0, 0, 0, 0);
    checks++;
    if (overflow !== 1'b1) begin
      failures++;
      $display("FAIL drop_beats_clear: overflow=%b, required 1", overflow);
    end
    step();
    clear_ovf = 1'b0;
    checks++;
    if (overflow !== 1'b0) begin
      failures++;
      $display("FAIL clear_after: overflow=%b, required 0", overflow);
    end
    drain("full_pop2");
  endtask

  task automatic test_reset_mid();
    wr_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      set_draw(1'b1, 90 + i, 1, 1);
      exp_q.push_back({1'b0, 8'(90 + i), 8'd1, 3'd1});
      step();
    end
    set_draw(1'b0, 0, 0, 0);
    rst_n = 1'b0;
    #1;
    checks++;
    if (wr_valid !== 1'b0 || busy !== 1'b0) begin
      failures++;
      $display("FAIL reset_mid_async: wr_valid=%b busy=%b, required 0 0", wr_valid, busy);
    end
    exp_q.delete();
    step();
    rst_n = 1'b1;
    wr_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step();
      checks++;
      if (wr_valid !== 1'b0) begin
        failures++;
        $display("FAIL reset_mid_stale: cycle %0d wr_valid=%b, required 0", i, wr_valid);
      end
    end
    set_draw(1'b1, 7, 8, 3);
    exp_q.push_back({1'b0, 8'd7, 8'd8, 3'd3});
    step();
    set_draw(1'b0, 0, 0, 0);
    checks++;
    if ({wr_valid, wr_x, wr_y} !== {1'b1, 8'd7, 8'd8}) begin
      failures++;
      $display("FAIL reset_mid_new: v=%b x=%0d y=%0d, required 1 7 8", wr_valid, wr_x, wr_y);
    end
    drain("reset_mid");
  endtask

`ifdef PIXEL_WRITE_ARB_BOUNDS_CHECK_EN
  task automatic test_bounds();
    wr_ready = 1'b1;
    set_draw(1'b1, 160, 5, 1);
    step();
    set_draw(1'b0, 0, 0, 0);
    checks++;
    if (wr_valid !== 1'b0 || reject_cnt !== 8'd1 || overflow !== 1'b0) begin
      failures++;
      $display("FAIL bounds_reject: v=%b rej=%0d ovf=%b, required 0 1 0",
               wr_valid, reject_cnt, overflow);
    end
    set_draw(1'b1, 159, 119, 4);
    exp_q.push_back({1'b0, 8'd159, 8'd119, 3'd4});
    step();
    set_draw(1'b0, 0, 0, 0);
    checks++;
    if ({wr_valid, wr_x, wr_y, reject_cnt} !== {1'b1, 8'd159, 8'd119, 8'd1}) begin
      failures++;
      $display("FAIL bounds_edge: v=%b x=%0d y=%0d rej=%0d, required 1 159 119 1",
               wr_valid, wr_x, wr_y, reject_cnt);
    end
    set_draw(1'b1, 3, 120, 0);
    set_rest(1'b1, 200, 3, 0);
    step();
    set_draw(1'b0, 0, 0, 0);
    set_rest(1'b0, 0, 0, 0);
    checks++;
    if (reject_cnt !== 8'd3 || overflow !== 1'b0) begin
      failures++;
      $display("FAIL bounds_both: rej=%0d ovf=%b, required 3 0", reject_cnt, overflow);
    end
    drain("bounds");
  endtask
`endif

  task automatic test_back_to_back();
    int mcnt;
    int free;
    logic d, r, rdy, clr, pop, acc_r, acc_d, drop, exp_ovf;
    mcnt = 0;
    exp_ovf = 1'b0;
    for (int i = 0; i < 300; i++) begin
      d   = ($urandom_range(0, 1) == 1);
      r   = ($urandom_range(0, 2) == 0);
      rdy = ($urandom_range(0, 3) != 0);
      clr = ($urandom_range(0, 15) == 0);
      pop = (mcnt > 0) && rdy;
      free = DEPTH - mcnt + int'(pop);
      acc_r = r && (free >= 1);
      acc_d = d && (free >= (acc_r ? 2 : 1));
      drop = (r && !acc_r) || (d && !acc_d);
      set_draw(d, $urandom_range(0, 150), $urandom_range(0, 110), $urandom_range(0, 7));
      set_rest(r, $urandom_range(0, 150), $urandom_range(0, 110), $urandom_range(0, 7));
      wr_ready = rdy;
      clear_ovf = clr;
      if (acc_r) exp_q.push_back({1'b1, restore_x, restore_y, restore_color});
      if (acc_d) exp_q.push_back({1'b0, draw_x, draw_y, draw_color});
      mcnt = mcnt + int'(acc_r) + int'(acc_d) - int'(pop);
      exp_ovf = drop ? 1'b1 : (clr ? 1'b0 : exp_ovf);
      step();
      checks++;
      if (overflow !== exp_ovf || busy !== (mcnt != 0)) begin
        failures++;
        $display("FAIL b2b_state: cycle %0d ovf=%b busy=%b, required %b %b",
                 i, overflow, busy, exp_ovf, (mcnt != 0));
      end
    end
    set_draw(1'b0, 0, 0, 0);
    set_rest(1'b0, 0, 0, 0);
    clear_ovf = 1'b0;
    drain("b2b");
`ifndef PIXEL_WRITE_ARB_BOUNDS_CHECK_EN
    checks++;
    if (reject_cnt !== 8'd0) begin
      failures++;
      $display("FAIL reject_tied: reject_cnt=%0d, required 0", reject_cnt);
    end
`endif
  endtask

  initial begin
    test_reset();
    test_single_restore();
    test_simultaneous();
    test_overflow();
    test_full_pop();
    test_reset_mid();
`ifdef PIXEL_WRITE_ARB_BOUNDS_CHECK_EN
    test_bounds();
`endif
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
